// File: rtl/mac_pkg.sv
// Shared definitions for the sequential dot-product engine: default widths,
// memory depth and the controller state encoding.
package mac_pkg;

    localparam int DEPTH      = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = $clog2(DEPTH);
    localparam int DEF_ACC_W  = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mac_acc.sv
// Multiply-accumulate unit: on en, adds the full unsigned a*b product
// (zero-extended) to the accumulator; clr restarts the sum at zero.
// The accumulator wraps modulo 2^ACC_W.
module mac_acc
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    acc_q;

    // Next accumulator value: clear has priority over accumulation.
    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register; reset forces a zero result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_seq.sv
// Sequential dot-product controller. Reads len words from two synchronous
// operand memories over a shared address and accumulates m1[i]*m2[i].
// Optional feature macro: MAC_SEQ_ABORT_EN adds an abort input that cancels
// a run in RUN or DRAIN without a done pulse.
module mac_seq
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
`ifdef MAC_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] m1_data,
    input  logic [DATA_W-1:0] m2_data,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1 << ADDR_W);

    state_e            state_d, state_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] last_d, last_q;
    logic              acc_en_d, acc_en_q;
    logic              clr;
    logic [ADDR_W:0]   len_eff;

    // Next-state, address counter and accumulator-clear decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        clr     = 1'b0;
        len_eff = (len > MAX_LEN) ? MAX_LEN : len;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr = 1'b1;
                    if (len_eff == '0) begin
                        // Empty run: no reads, result is the cleared sum.
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        addr_d  = '0;
                        last_d  = ADDR_W'(len_eff - (ADDR_W+1)'(1));
                    end
                end
            end
            ST_RUN: begin
`ifdef MAC_SEQ_ABORT_EN
                if (abort) begin
                    state_d = ST_IDLE;
                end else
`endif
                if (addr_q == last_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
`ifdef MAC_SEQ_ABORT_EN
                if (abort) begin
                    state_d = ST_IDLE;
                end else
`endif
                begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory data arrives one cycle after the read strobe, so the
    // accumulate enable is the strobe delayed by one cycle.
    always_comb begin
        acc_en_d = rd_en;
    end

    // Control registers: state, address, last address and accumulate enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            acc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            acc_en_q <= acc_en_d;
        end
    end

    assign rd_en = (state_q == ST_RUN);
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign addr  = addr_q;

    mac_acc #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (acc_en_q),
        .a     (m1_data),
        .b     (m2_data),
        .acc   (result)
    );

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: directed runs with hand-computed results, checked by
// a scoreboard queue drained by an independent done/read monitor.
module tb_mac_seq;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] m1_data = '0;
    logic [DATA_W-1:0] m2_data = '0;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
`ifdef MAC_SEQ_ABORT_EN
    logic              abort;
`endif

    logic [DATA_W-1:0] m1 [16];
    logic [DATA_W-1:0] m2 [16];

    typedef struct {
        int res;
        int c0;
        int lat;
        int nrd;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;

    mac_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .len     (len),
`ifdef MAC_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .rd_en   (rd_en),
        .addr    (addr),
        .m1_data (m1_data),
        .m2_data (m2_data),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        if (rd_en) begin
            m1_data <= m1[addr];
            m2_data <= m2[addr];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // 0: all ones, 1: m[i]=i, 2: all 255
    task automatic load(input int kind);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0:       begin m1[i] = 8'd1;        m2[i] = 8'd1;        end
                1:       begin m1[i] = DATA_W'(i);  m2[i] = DATA_W'(i);  end
                default: begin m1[i] = 8'd255;      m2[i] = 8'd255;      end
            endcase
        end
    endtask

    // Pulse start for one edge and record the expectation for that run.
    task automatic do_start(input int n, input int res, input int lat, input int nrd);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        len   = (ADDR_W+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        e.res = res;
        e.c0  = cyc;
        e.lat = lat;
        e.nrd = nrd;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 200);
        if (n >= 200) fail(name);
    endtask

    task automatic wait_addr(input int a, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rd_en && addr == ADDR_W'(a)) && n < 100);
        if (n >= 100) fail(name);
    endtask

    // Monitor: checks the read address sequence and scores each done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!busy) rd_cnt = 0;
            if (rd_en) begin
                chk("rd_addr", addr, rd_cnt);
                rd_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    fail("spurious_done");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("done_latency", cyc - e.c0, e.lat);
                    chk("rd_count", rd_cnt, e.nrd);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
`ifdef MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        load(0);
        #12;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        #11 rst_n = 1'b1;

        // All ones, full length.
        load(0);
        do_start(16, 16, 17, 16);
        wait_idle("ones16");

        // m[i]=i: full length and a short run.
        load(1);
        do_start(16, 1240, 17, 16);
        wait_idle("idx16");
        do_start(5, 30, 6, 5);
        wait_idle("idx5");

        // Maximum products, then an empty run.
        load(2);
        do_start(16, 1040400, 17, 16);
        wait_idle("max16");
        chk("hold_result", result, 1040400);
        do_start(0, 0, 0, 0);
        wait_idle("len0");

        // Oversized length is clamped to 16.
        load(1);
        do_start(20, 1240, 17, 16);
        wait_idle("len20");

        // A second start mid-run must be ignored.
        do_start(5, 30, 6, 5);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1;
        len   = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("restart_ignored");

        // Asynchronous reset in the middle of a run.
        do_start(16, 1240, 17, 16);
        wait_addr(7, "find_addr7");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_start(3, 5, 4, 3);
        wait_idle("after_reset");

`ifdef MAC_SEQ_ABORT_EN
        // Abort mid-run: back to idle with no done pulse.
        do_start(16, 1240, 17, 16);
        wait_addr(4, "find_addr4");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_en", rd_en, 0);
        do_start(5, 30, 6, 5);
        wait_idle("after_abort");
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand width of each memory word.
REQ-002 SHALL have parameter ADDR_W, default 4: memory address width (16 entries).
REQ-003 SHALL have parameter ACC_W, default 20: accumulator and result width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: request a dot-product run; sampled only in IDLE.
REQ-007 SHALL have port len, input, ADDR_W+1: number of entries, 0..16; sampled with start.
REQ-008 SHALL have port rd_en, output, 1: read strobe to both operand memories.
REQ-009 SHALL have port addr, output, ADDR_W: shared read address for both memories.
REQ-010 SHALL have port m1_data, input, DATA_W: operand A; valid one cycle after rd_en (synchronous RAM).
REQ-011 SHALL have port m2_data, input, DATA_W: operand B; same timing as m1_data.
REQ-012 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when result is final.
REQ-014 SHALL have port result, output, ACC_W: unsigned sum of m1[i]*m2[i] for i = 0..len-1.

Function
REQ-015 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE with start=1 and len>0 SHALL: latch len, clear the accumulator, drive addr=0 and rd_en=1, and go to RUN.
REQ-017 RUN SHALL issue one address per cycle (0, 1, ... len-1) with rd_en=1, then go to DRAIN after issuing len-1.
REQ-018 The block SHALL add m1_data*m2_data (unsigned, full 2*DATA_W product, zero-extended) to the accumulator in the cycle after each rd_en.
REQ-019 DRAIN SHALL perform the final accumulate, with rd_en=0, then go to DONE.
REQ-020 DONE SHALL hold done=1 for exactly one cycle with result final, then return to IDLE.
REQ-021 If start is sampled on edge E0, done SHALL be high in the cycle following edge E0+len+1.
REQ-022 result SHALL hold its value until the next accepted start; it SHALL change only via accumulation.
REQ-023 With start=1 and len=0, the block SHALL go directly to DONE with result=0 and no rd_en pulse.
REQ-024 The block SHALL treat len>16 as 16.
REQ-025 The block SHALL ignore start while busy=1.
REQ-026 Outside RUN, rd_en SHALL be 0 and addr SHALL hold its last value.
REQ-027 The accumulator SHALL wrap modulo 2^ACC_W; this cannot occur at the default widths (max 1,040,400).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, rd_en=0, addr=0, busy=0, done=0 and result=0, including mid-run.
REQ-029 After reset releases, the block SHALL accept start on the first rising edge.

Configuration
REQ-030 With macro MAC_SEQ_ABORT_EN defined, the block SHALL add input abort (1 bit).
REQ-031 With MAC_SEQ_ABORT_EN defined, abort=1 in RUN or DRAIN SHALL go to IDLE on the next edge, with rd_en=0 and no done pulse.
REQ-032 With MAC_SEQ_ABORT_EN defined, an aborted run SHALL leave result as a partial sum; abort SHALL be ignored in IDLE and DONE.
REQ-033 Without MAC_SEQ_ABORT_EN, the abort port and its logic SHALL be absent and runs SHALL always complete.

Structure
REQ-034 Package mac_pkg SHALL hold the DATA_W, ADDR_W and ACC_W defaults, the DEPTH=16 constant and the state enumeration.
REQ-035 Multiply-accumulate SHALL be sub-module mac_acc (inputs clr, en, a, b; output acc), instantiated once; the FSM and address counter stay in mac_seq.

Verification
REQ-036 m1[i]=m2[i]=1, len=16 -> 16 rd_en cycles with addr 0..15, done 17 cycles after start edge, result=16.
REQ-037 m1[i]=m2[i]=i, len=16 -> result=1240; with len=5 -> result=30, done 6 cycles after start.
REQ-038 All words 255, len=16 -> result=1040400; then len=0 -> done next cycle, result=0, rd_en never high.
REQ-039 Start pulsed again mid-run -> ignored; first run completes with a single done and the correct result.
REQ-040 rst_n low at addr=7 -> outputs zero immediately; next start len=3 with data i -> result=5.
REQ-041 With MAC_SEQ_ABORT_EN, abort at addr=4 -> IDLE next cycle, no done, busy=0; next run is correct.
